bpred_resolve: RTL
==================

BPRED_RESOLVE -- requirements
Module: bpred_resolve

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 8 (power of 2, 2..32): in-flight prediction records.
REQ-002 SHALL have ports, one per line:
 clk  in  1  sole clock, all state on rising edge
 reset  in  1  synchronous, active-high
 soin_bpredictor_stall  in  1  global stall; freezes push, pop and state
 fetch_valid  in  1  fetch issued a predicted instruction this cycle
 fetch_PC4  in  32  PC+4 of that instruction
 fetch_p_dir  in  1  predicted direction
 fetch_bimodal  in  12  {index[7:0], 2'b pad, counter[1:0]} from predictor
 fetch_bit_carry  in  9  predictor memory low bits to write back
 exec_valid  in  1  execute retires the oldest queued instruction
 exec_is_branch  in  1  instruction is a branch
 exec_dir  in  1  actual direction
 exec_target  in  32  actual taken target
 execute_bpredictor_update  out  1  write predictor this cycle
 execute_bpredictor_PC4 / _target  out  32 each
 execute_bpredictor_dir / _miss  out  1 each
 execute_bpredictor_bimodal  out  12  record's bimodal field
 up_btb_data  out  30  exec_target[31:2]
 up_carry_data  out  9  record's bit_carry
 byte_en  out  4  predictor memory byte enables
 flush  out  1  one-cycle mispredict flush
 redirect_PC  out  32  correct next fetch PC
 queue_full  out  1  count == QUEUE_DEPTH
 err_sticky  out  2  {overflow, underflow}, sticky until reset
 bpredictor_resolve_debug  out  32  debug readback
 resolve_debug_sel  in  1  debug select
REQ-003 Clock port SHALL be clk; reset port SHALL be reset, synchronous, active-high.

Function
REQ-004 SHALL hold records {PC4, p_dir, bimodal, bit_carry} in a circular FIFO, rd/wr pointers wrapping modulo QUEUE_DEPTH, count 0..QUEUE_DEPTH.
REQ-005 Push = fetch_valid & ~stall & ~full & state==NORMAL; pop = exec_valid & ~stall & count!=0; simultaneous push+pop with no miss SHALL keep count unchanged, including when full.
REQ-006 Push when full SHALL be dropped and set err_sticky[1]; exec_valid & ~stall when empty SHALL be ignored and set err_sticky[0].
REQ-007 miss = exec_is_branch ? (p_dir != exec_dir) : p_dir, using the popped record.
REQ-008 Outputs SHALL be registered: a pop in cycle N produces results in cycle N+1 only; update asserted only if exec_is_branch or miss; update dir = exec_is_branch & exec_dir.
REQ-009 byte_en SHALL be 4'b1111 when update dir=1 (BTB + bimodal), else 4'b0001 (bimodal only).
REQ-010 On miss in cycle N: flush=1 and redirect_PC = (dir ? exec_target : record PC4) in N+1; count, pointers cleared in N; any same-cycle push discarded; state -> FLUSH.
REQ-011 FSM: NORMAL -> FLUSH on miss; FLUSH -> NORMAL after one unstalled cycle; pushes blocked in FLUSH; a stalled FLUSH cycle SHALL hold FLUSH.
REQ-012 During stall, update and flush SHALL be 0 and all state held; data outputs may hold last value.

Reset
REQ-013 reset SHALL clear count, pointers, err_sticky, all outputs to 0 and state to NORMAL within one cycle, overriding any concurrent push/pop/miss.
REQ-014 Reset asserted mid-operation SHALL discard all queued records; no update/flush SHALL appear in the cycle after reset.

Configuration
REQ-015 Macro BPRED_RESOLVE_STATS_EN: when defined, 32-bit wrapping counters update_count and miss_count increment on each asserted update / miss, bpredictor_resolve_debug = sel ? miss_count : update_count; when undefined, no counters exist and bpredictor_resolve_debug SHALL be 0.

Verification
REQ-016 Push PC4=0x104 p_dir=0; pop exec_is_branch=1 dir=0 -> next cycle update=1, miss=0, byte_en=0001, flush=0.
REQ-017 Push PC4=0x204 p_dir=0; pop dir=1 target=0x400 -> update=1, miss=1, dir=1, byte_en=1111, up_btb_data=0x100, flush=1, redirect_PC=0x400, count=0.
REQ-018 Push 8 records (depth 8), 9th push -> queue_full=1, err_sticky=2'b10; simultaneous push+pop at full -> count stays 8.
REQ-019 Non-branch with p_dir=1, PC4=0x30 -> update=1, dir=0, miss=1, redirect_PC=0x30; push in the miss cycle and the following FLUSH cycle dropped.
REQ-020 Stall asserted during a mispredicting pop -> no pop, no flush; deassert -> flush next cycle; reset with 3 queued -> count=0, no update.
REQ-021 With BPRED_RESOLVE_STATS_EN, 5 updates incl. 2 misses -> debug=5 (sel=0), 2 (sel=1); without macro debug=0.

Source files
------------

// File: rtl/bpred_resolve.sv
// Branch-prediction resolve stage: FIFO of in-flight predictions, one record popped
// per retired instruction, registered predictor update / flush. Optional: BPRED_RESOLVE_STATS_EN.
module bpred_resolve #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        soin_bpredictor_stall,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_PC4,
    input  logic        fetch_p_dir,
    input  logic [11:0] fetch_bimodal,
    input  logic [8:0]  fetch_bit_carry,
    input  logic        exec_valid,
    input  logic        exec_is_branch,
    input  logic        exec_dir,
    input  logic [31:0] exec_target,
    output logic        execute_bpredictor_update,
    output logic [31:0] execute_bpredictor_PC4,
    output logic [31:0] execute_bpredictor_target,
    output logic        execute_bpredictor_dir,
    output logic        execute_bpredictor_miss,
    output logic [11:0] execute_bpredictor_bimodal,
    output logic [29:0] up_btb_data,
    output logic [8:0]  up_carry_data,
    output logic [3:0]  byte_en,
    output logic        flush,
    output logic [31:0] redirect_PC,
    output logic        queue_full,
    output logic [1:0]  err_sticky,
    output logic [31:0] bpredictor_resolve_debug,
    input  logic        resolve_debug_sel
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc4;
        logic        p_dir;
        logic [11:0] bimodal;
        logic [8:0]  bit_carry;
    } rec_t;

    typedef enum logic {NORMAL, FLUSH} state_t;

    rec_t             mem [QUEUE_DEPTH];
    rec_t             head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    state_t           state_nxt;

    logic active;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic miss_now;
    logic overflow;
    logic underflow;

    logic        upd_nxt;
    logic        dir_nxt;
    logic [3:0]  be_nxt;
    logic [31:0] redirect_nxt;

    assign head       = mem[rd_ptr];
    assign queue_full = full;

    // A pop frees a slot in the same cycle, so push at full proceeds when paired with a pop.
    always_comb begin
        active    = ~soin_bpredictor_stall;
        full      = (count == CNT_W'(QUEUE_DEPTH));
        empty     = (count == '0);
        pop       = exec_valid & active & ~empty;
        miss_now  = pop & (exec_is_branch ? (head.p_dir != exec_dir) : head.p_dir);
        push      = fetch_valid & active & (state == NORMAL) & (~full | pop) & ~miss_now;
        overflow  = fetch_valid & active & (state == NORMAL) & full & ~pop;
        underflow = exec_valid & active & empty;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= NORMAL;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (active) begin
            if (miss_now)             state_nxt = FLUSH;
            else if (state == FLUSH)  state_nxt = NORMAL;
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        upd_nxt      = pop & (exec_is_branch | miss_now);
        dir_nxt      = exec_is_branch & exec_dir;
        be_nxt       = dir_nxt ? 4'b1111 : 4'b0001;
        redirect_nxt = dir_nxt ? exec_target : head.pc4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (miss_now) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc4: fetch_PC4, p_dir: fetch_p_dir,
                                   bimodal: fetch_bimodal, bit_carry: fetch_bit_carry};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= '0;
        end else begin
            if (overflow)  err_sticky[1] <= 1'b1;
            if (underflow) err_sticky[0] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            execute_bpredictor_update  <= 1'b0;
            execute_bpredictor_PC4     <= '0;
            execute_bpredictor_target  <= '0;
            execute_bpredictor_dir     <= 1'b0;
            execute_bpredictor_miss    <= 1'b0;
            execute_bpredictor_bimodal <= '0;
            up_btb_data                <= '0;
            up_carry_data              <= '0;
            byte_en                    <= '0;
            flush                      <= 1'b0;
            redirect_PC                <= '0;
        end else begin
            execute_bpredictor_update <= upd_nxt;
            flush                     <= miss_now;
            if (pop) begin
                execute_bpredictor_PC4     <= head.pc4;
                execute_bpredictor_target  <= exec_target;
                execute_bpredictor_dir     <= dir_nxt;
                execute_bpredictor_miss    <= miss_now;
                execute_bpredictor_bimodal <= head.bimodal;
                up_btb_data                <= exec_target[31:2];
                up_carry_data              <= head.bit_carry;
                byte_en                    <= be_nxt;
                redirect_PC                <= redirect_nxt;
            end
        end
    end

`ifdef BPRED_RESOLVE_STATS_EN
    logic [31:0] update_count;
    logic [31:0] miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            update_count <= '0;
            miss_count   <= '0;
        end else begin
            if (upd_nxt)  update_count <= update_count + 32'd1;
            if (miss_now) miss_count   <= miss_count + 32'd1;
        end
    end

    assign bpredictor_resolve_debug = resolve_debug_sel ? miss_count : update_count;
`else
    logic unused_debug_sel;
    assign unused_debug_sel         = resolve_debug_sel;
    assign bpredictor_resolve_debug = '0;
`endif

endmodule
